truth_table_scorer: RTL and testbench
=====================================

TRUTH_TABLE_SCORER -- requirements
Module: truth_table_scorer

Interface
REQ-001 Parameter SETTLE, default 4: clock cycles the probe pattern is held before the candidate's outputs are sampled; legal range 1..255.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request one full 16-row evaluation; sampled only in IDLE.
REQ-005 abort  input  1  cancel an evaluation in progress.
REQ-006 target  input  64  expected truth table; bit 4*r+k is the expected value of candidate output k for input row r.
REQ-007 probe0..probe3  output  1 each  drive candidate inputs input0..input3; probe_k = bit k of current row index.
REQ-008 sense0..sense3  input  1 each  candidate outputs output0..output3 returned to the scorer.
REQ-009 busy  output  1  high from the cycle after start is accepted until the evaluation ends.
REQ-010 done  output  1  single-cycle pulse on completion.
REQ-011 score  output  7  count of matching output bits, 0..64.
REQ-012 rowmiss  output  16  bit r set when any sense bit mismatched in row r.

Function
REQ-013 The block SHALL implement states IDLE, DRIVE, SAMPLE and FIN.
REQ-014 In IDLE with start=1 and abort=0, the block SHALL latch target, clear score and rowmiss, set row=0 and settle count=0, and enter DRIVE.
REQ-015 In DRIVE the block SHALL hold probe0..3 at the current row and stay exactly SETTLE cycles, then enter SAMPLE.
REQ-016 In SAMPLE, for k=0..3, the block SHALL compare sense_k with latched target[4*row+k] in that one cycle.
REQ-017 In SAMPLE, the block SHALL add the number of matches (0..4) to score.
REQ-018 In SAMPLE, the block SHALL set rowmiss[row] if the match count is below 4.
REQ-019 From SAMPLE, the block SHALL increment row and return to DRIVE for rows 0..14; from row 15 it SHALL enter FIN.
REQ-020 Each row SHALL occupy SETTLE+1 cycles; probe values SHALL change only on the edge leaving SAMPLE.
REQ-021 In FIN the block SHALL assert done for exactly one cycle, deassert busy, and return to IDLE.
REQ-022 done SHALL rise 16*(SETTLE+1)+1 cycles after the edge that accepted start; with SETTLE=4 this is 81 cycles.
REQ-023 score and rowmiss SHALL hold their final values in IDLE until the next accepted start.
REQ-024 busy SHALL be 1 in DRIVE and SAMPLE and 0 in IDLE and FIN.
REQ-025 start asserted while busy=1 SHALL be ignored; changes on target while busy=1 SHALL be ignored.
REQ-026 abort=1 in any state other than IDLE SHALL force IDLE on the next edge.
REQ-027 On abort, score and rowmiss SHALL be cleared, probe0..3 SHALL be set to 0, and done SHALL not pulse.
REQ-028 abort has priority over the state transition that would otherwise occur in that cycle.
REQ-029 start and abort both high in IDLE SHALL leave the block in IDLE.
REQ-030 score SHALL never exceed 64; its 7-bit width requires no saturation logic.
REQ-031 The row counter SHALL be 4 bits and SHALL not wrap during an evaluation.

Reset
REQ-032 rst_n=0 SHALL, immediately and independent of clk, force IDLE, row=0, settle count=0, probe0..3=0, busy=0, done=0, score=0 and rowmiss=0.
REQ-033 Reset asserted mid-evaluation SHALL discard all partial results; no done pulse SHALL follow release.
REQ-034 The first start SHALL be accepted on the first rising edge after rst_n is released.

Verification
REQ-035 Loopback (sense_k=probe_k), target[4r+k]=r[k], SETTLE=4, pulse start -> done at cycle 81, score=64, rowmiss=16'h0000.
REQ-036 sense0..3 tied 0, target=64'hFFFF_FFFF_FFFF_FFFF -> score=0, rowmiss=16'hFFFF.
REQ-037 Loopback with target bit 4*9+2 inverted -> score=63, rowmiss=16'h0200.
REQ-038 abort during row 7, and a start pulse issued while busy -> IDLE next cycle, no done pulse, score=0, probes=0, busy=0; the mid-run start has no effect.
REQ-039 rst_n low during row 3, then released, then start -> outputs zero during reset, then a fresh 81-cycle run with the correct score.
REQ-040 SETTLE=1 loopback -> done at cycle 33, each probe pattern held 2 cycles, score=64.

Source files
------------

// File: rtl/truth_table_scorer.sv
`default_nettype none
// ============================================================================
// Module      : truth_table_scorer
// Description : Drives a 4-input candidate through all 16 input rows. Each
//               row is held SETTLE cycles and then sampled once. The score is
//               the number of candidate output bits that match the target
//               table, and rowmiss flags every row with at least one mismatch.
// Revision    : 1.0  initial release
// ============================================================================
module truth_table_scorer #(
  parameter int unsigned SETTLE = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        abort_i,
  input  logic [63:0] target_i,
  output logic        probe0_o,
  output logic        probe1_o,
  output logic        probe2_o,
  output logic        probe3_o,
  input  logic        sense0_i,
  input  logic        sense1_i,
  input  logic        sense2_i,
  input  logic        sense3_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [6:0]  score_o,
  output logic [15:0] rowmiss_o
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_FIN    = 2'd3
  } state_t;

  // Terminal value of the settle counter; the row is sampled on the next cycle.
  localparam logic [7:0] C_SETTLE_LAST = 8'(SETTLE - 1);

  state_t      state_q, state_d;
  logic [3:0]  row_q, row_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [63:0] tgt_q, tgt_d;
  logic [6:0]  score_q, score_d;
  logic [15:0] rowmiss_q, rowmiss_d;
  logic        done_q, done_d;

  logic [3:0]  w_sense;
  logic [3:0]  w_expect;
  logic [3:0]  w_match;
  logic [2:0]  w_hits;

  assign w_sense  = {sense3_i, sense2_i, sense1_i, sense0_i};
  assign w_expect = tgt_q[{row_q, 2'b00} +: 4];
  assign w_match  = ~(w_sense ^ w_expect);
  assign w_hits   = 3'(w_match[0]) + 3'(w_match[1]) + 3'(w_match[2]) + 3'(w_match[3]);

  // Next-state logic: sequencing, accumulation, and abort override last.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    cnt_d     = cnt_q;
    tgt_d     = tgt_q;
    score_d   = score_q;
    rowmiss_d = rowmiss_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_i && !abort_i) begin
          tgt_d     = target_i;
          score_d   = 7'd0;
          rowmiss_d = 16'h0000;
          row_d     = 4'd0;
          cnt_d     = 8'd0;
          state_d   = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (cnt_q == C_SETTLE_LAST) begin
          cnt_d   = 8'd0;
          state_d = S_SAMPLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_SAMPLE: begin
        score_d = score_q + 7'(w_hits);
        if (w_hits != 3'd4) begin
          rowmiss_d[row_q] = 1'b1;
        end
        // Row stays at 15 after the last sample so the counter never wraps.
        if (row_q == 4'd15) begin
          state_d = S_FIN;
        end else begin
          row_d   = row_q + 4'd1;
          state_d = S_DRIVE;
        end
      end
      S_FIN: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort_i && (state_q != S_IDLE)) begin
      state_d   = S_IDLE;
      row_d     = 4'd0;
      cnt_d     = 8'd0;
      score_d   = 7'd0;
      rowmiss_d = 16'h0000;
      done_d    = 1'b0;
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      row_q     <= 4'd0;
      cnt_q     <= 8'd0;
      tgt_q     <= 64'd0;
      score_q   <= 7'd0;
      rowmiss_q <= 16'h0000;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      cnt_q     <= cnt_d;
      tgt_q     <= tgt_d;
      score_q   <= score_d;
      rowmiss_q <= rowmiss_d;
      done_q    <= done_d;
    end
  end

  assign probe0_o  = row_q[0];
  assign probe1_o  = row_q[1];
  assign probe2_o  = row_q[2];
  assign probe3_o  = row_q[3];
  assign busy_o    = (state_q == S_DRIVE) || (state_q == S_SAMPLE);
  assign done_o    = done_q;
  assign score_o   = score_q;
  assign rowmiss_o = rowmiss_q;

endmodule
`default_nettype wire

// File: tb/tb_truth_table_scorer.sv
`default_nettype none
// ============================================================================
// Module      : tb_truth_table_scorer
// Description : Directed self-checking bench for truth_table_scorer with
//               SETTLE=4 and SETTLE=1 instances.
// Revision    : 1.0  initial release
// ============================================================================
module tb_truth_table_scorer;

  localparam logic [63:0] C_T_LB = 64'hFEDC_BA98_7654_3210;

  logic        clk;
  logic        rst_n;
  logic        start, start1, abort;
  logic [63:0] target;
  logic        lb;
  logic [3:0]  sense_fix;

  logic [3:0]  probe, probe1, sense, sense1;
  logic        busy, done, busy1, done1;
  logic [6:0]  score, score1;
  logic [15:0] rowmiss, rowmiss1;

  int n_checks = 0;
  int n_errors = 0;

  assign sense  = lb ? probe : sense_fix;
  assign sense1 = probe1;

  truth_table_scorer #(.SETTLE(4)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort), .target_i(target),
    .probe0_o(probe[0]), .probe1_o(probe[1]), .probe2_o(probe[2]), .probe3_o(probe[3]),
    .sense0_i(sense[0]), .sense1_i(sense[1]), .sense2_i(sense[2]), .sense3_i(sense[3]),
    .busy_o(busy), .done_o(done), .score_o(score), .rowmiss_o(rowmiss)
  );

  truth_table_scorer #(.SETTLE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(start1), .abort_i(abort), .target_i(target),
    .probe0_o(probe1[0]), .probe1_o(probe1[1]), .probe2_o(probe1[2]), .probe3_o(probe1[3]),
    .sense0_i(sense1[0]), .sense1_i(sense1[1]), .sense2_i(sense1[2]), .sense3_i(sense1[3]),
    .busy_o(busy1), .done_o(done1), .score_o(score1), .rowmiss_o(rowmiss1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pulse start on the chosen instance; lat = cycles from accept edge to done.
  task automatic do_run(input bit sel, input bit scramble, output int lat, output int bad_probe);
    @(negedge clk);
    if (sel) start1 = 1'b1; else start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start1 = 1'b0;
    check("busy_after_accept", sel ? busy1 : busy, 1);
    if (scramble) target = ~target;
    lat = -1;
    bad_probe = 0;
    if (sel && probe1 != 4'd0) bad_probe++;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (sel && i < 32 && probe1 != 4'(i / 2)) bad_probe++;
      if ((sel ? done1 : done) && lat < 0) begin
        lat = i;
        break;
      end
    end
  endtask

  // Wait until the SETTLE=4 instance presents row r, bounded.
  task automatic wait_row(input logic [3:0] r);
    bit found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (probe == r) begin
        found = 1'b1;
        break;
      end
    end
    check("wait_row_reached", 64'(found), 1);
  endtask

  int lat, badp;
  bit seen;

  initial begin
    rst_n = 1'b0; start = 1'b0; start1 = 1'b0; abort = 1'b0;
    target = 64'd0; lb = 1'b1; sense_fix = 4'd0;
    #23;
    check("reset_outputs", {busy, done, score, rowmiss, probe}, 0);

    // Release reset with start already high: first edge must accept.
    @(negedge clk);
    target = C_T_LB;
    rst_n  = 1'b1;
    start  = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("first_edge_accept", busy, 1);
    for (int i = 0; i < 100; i++) @(posedge clk);
    #1;
    check("first_run_score", score, 64);

    // Loopback, target changed while busy must be ignored.
    target = C_T_LB;
    do_run(1'b0, 1'b1, lat, badp);
    check("lb_latency", 64'(lat), 81);
    check("lb_score", score, 64);
    check("lb_rowmiss", rowmiss, 16'h0000);
    check("lb_busy_at_done", busy, 0);
    @(posedge clk); #1;
    check("done_single_cycle", done, 0);
    repeat (5) @(posedge clk);
    #1;
    check("score_held_idle", score, 64);

    // All outputs stuck at 0 against an all-ones table.
    lb = 1'b0; sense_fix = 4'd0;
    target = 64'hFFFF_FFFF_FFFF_FFFF;
    do_run(1'b0, 1'b0, lat, badp);
    check("zero_score", score, 0);
    check("zero_rowmiss", rowmiss, 16'hFFFF);

    // Single flipped bit in row 9, output 2.
    lb = 1'b1;
    target = C_T_LB ^ (64'd1 << 38);
    do_run(1'b0, 1'b0, lat, badp);
    check("flip_latency", 64'(lat), 81);
    check("flip_score", score, 63);
    check("flip_rowmiss", rowmiss, 16'h0200);

    // Abort during row 7 with a stray start while busy.
    target = C_T_LB;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_row(4'd5);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_row(4'd7);
    @(negedge clk); abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_score", score, 0);
    check("abort_rowmiss", rowmiss, 0);
    check("abort_probe", probe, 0);
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen = 1'b1;
    end
    check("abort_no_done", 64'(seen), 0);

    // Reset during row 3 discards everything immediately.
    do_run(1'b0, 1'b0, lat, badp);
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    wait_row(4'd3);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_outputs", {busy, done, score, rowmiss, probe}, 0);
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    check("midreset_no_done", 64'(seen), 0);
    do_run(1'b0, 1'b0, lat, badp);
    check("post_reset_latency", 64'(lat), 81);
    check("post_reset_score", score, 64);

    // SETTLE=1 instance.
    target = C_T_LB;
    do_run(1'b1, 1'b0, lat, badp);
    check("s1_latency", 64'(lat), 33);
    check("s1_probe_hold", 64'(badp), 0);
    check("s1_score", score1, 64);
    check("s1_rowmiss", rowmiss1, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
